// File: rtl/moxie_wb_master.sv
// Bridge from the MoxieLite native CPU bus (active-low strobes, wait handshake) to a
// Wishbone B3 classic master, with bus-error/timeout abort and sticky fault address.
module moxie_wb_master #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = '1,
  localparam int                   SEL_WIDTH  = DATA_WIDTH / 8,
  localparam int                   LSB        = $clog2(SEL_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-LSB-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]     cpu_dat_i,
  output logic [DATA_WIDTH-1:0]     cpu_dat_o,
  input  logic                      cpu_rd_n_i,
  input  logic                      cpu_wr_n_i,
  input  logic [SEL_WIDTH-1:0]      cpu_be_n_i,
  output logic                      cpu_wait_n_o,
  output logic                      cpu_berr_o,
  output logic [ADDR_WIDTH-1:0]     berr_addr_o,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [SEL_WIDTH-1:0]      wb_sel_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] timer;
  logic        req;
  logic        wr;
  logic        tmo_hit;

  assign req     = !cpu_rd_n_i || !cpu_wr_n_i;
  assign wr      = !cpu_wr_n_i;
  assign tmo_hit = (TIMEOUT != 0) && (timer == TMO_LAST);

  // NOTE: continuous assign over a full expression cannot infer a latch; the IDLE
  // term must follow the CPU strobe in the same cycle, so it is not registered.
  assign cpu_wait_n_o = (state == DONE) || ((state == IDLE) && !req);
  assign wb_cyc_o     = wb_stb_o;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      timer       <= '0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      cpu_dat_o   <= '0;
      cpu_berr_o  <= 1'b0;
      berr_addr_o <= '0;
    end else begin
      cpu_berr_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            wb_adr_o <= ADDR_WIDTH'(cpu_addr_i) << LSB;
            wb_dat_o <= cpu_dat_i;
            wb_we_o  <= wr;
            wb_sel_o <= wr ? ~cpu_be_n_i : '1;
            timer    <= '0;
            // A write with no lanes enabled completes without touching the bus.
            if (wr && (&cpu_be_n_i)) begin
              state <= DONE;
            end else begin
              wb_stb_o <= 1'b1;
              state    <= BUS;
            end
          end
        end
        BUS: begin
          // Slave error beats ack; ack beats a timeout on the same edge.
          if (wb_err_i || (!wb_ack_i && tmo_hit)) begin
            wb_stb_o    <= 1'b0;
            cpu_berr_o  <= 1'b1;
            berr_addr_o <= wb_adr_o;
            if (!wb_we_o) cpu_dat_o <= ERR_DATA;
            state <= DONE;
          end else if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            if (!wb_we_o) cpu_dat_o <= wb_dat_i;
            state <= DONE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          wb_stb_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moxie_wb_master.sv
// Directed bench for moxie_wb_master: one instance with TIMEOUT=8, one with timeout disabled,
// sharing CPU and slave stimulus; a small programmable Wishbone slave supplies responses.
module tb_moxie_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [30:0] cpu_addr_i = '0;
  logic [15:0] cpu_dat_i = '0;
  logic        cpu_rd_n_i = 1'b1;
  logic        cpu_wr_n_i = 1'b1;
  logic [1:0]  cpu_be_n_i = 2'b11;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  logic [15:0] cpu_dat_o, z_cpu_dat_o;
  logic        cpu_wait_n_o, z_cpu_wait_n_o;
  logic        cpu_berr_o, z_cpu_berr_o;
  logic [31:0] berr_addr_o, z_berr_addr_o;
  logic [31:0] wb_adr_o, z_wb_adr_o;
  logic [15:0] wb_dat_o, z_wb_dat_o;
  logic [1:0]  wb_sel_o, z_wb_sel_o;
  logic        wb_we_o, z_wb_we_o;
  logic        wb_cyc_o, z_wb_cyc_o;
  logic        wb_stb_o, z_wb_stb_o;

  always #5 clk_i = ~clk_i;

  moxie_wb_master #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o),
    .cpu_rd_n_i(cpu_rd_n_i), .cpu_wr_n_i(cpu_wr_n_i), .cpu_be_n_i(cpu_be_n_i),
    .cpu_wait_n_o(cpu_wait_n_o), .cpu_berr_o(cpu_berr_o), .berr_addr_o(berr_addr_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  moxie_wb_master #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .TIMEOUT(0)) dut_notmo (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(z_cpu_dat_o),
    .cpu_rd_n_i(cpu_rd_n_i), .cpu_wr_n_i(cpu_wr_n_i), .cpu_be_n_i(cpu_be_n_i),
    .cpu_wait_n_o(z_cpu_wait_n_o), .cpu_berr_o(z_cpu_berr_o), .berr_addr_o(z_berr_addr_o),
    .wb_adr_o(z_wb_adr_o), .wb_dat_o(z_wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(z_wb_sel_o),
    .wb_we_o(z_wb_we_o), .wb_cyc_o(z_wb_cyc_o), .wb_stb_o(z_wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Slave: acks after slv_waits wait states while stb is high; silent mode never responds.
  int          slv_waits = 0;
  int          slv_cnt = 0;
  logic        slv_err = 1'b0;
  logic        slv_silent = 1'b0;
  logic [15:0] slv_data = '0;

  always @(posedge clk_i) begin
    #2;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (wb_stb_o && !slv_silent) begin
      if (slv_cnt >= slv_waits) begin
        wb_ack_i = 1'b1;
        wb_err_i = slv_err;
        wb_dat_i = slv_data;
      end
      slv_cnt++;
    end else begin
      slv_cnt = 0;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last access, as seen by the CPU and on the bus.
  int          acc_cycles;
  int          acc_stb_cycles;
  logic [15:0] acc_rdata;
  logic        acc_berr;
  logic [31:0] acc_adr;
  logic [15:0] acc_wdat;
  logic [1:0]  acc_sel;
  logic        acc_we;

  // Called 1 time unit after a rising edge; returns in the release cycle with the request dropped.
  task automatic access(input logic is_wr, input logic [30:0] addr, input logic [15:0] data,
                        input logic [1:0] be_n);
    cpu_addr_i     = addr;
    cpu_dat_i      = data;
    cpu_be_n_i     = be_n;
    cpu_wr_n_i     = !is_wr;
    cpu_rd_n_i     = is_wr;
    acc_cycles     = 0;
    acc_stb_cycles = 0;
    forever begin
      @(posedge clk_i);
      #1;
      acc_cycles++;
      if (acc_cycles == 1) begin
        acc_adr  = wb_adr_o;
        acc_wdat = wb_dat_o;
        acc_sel  = wb_sel_o;
        acc_we   = wb_we_o;
      end
      if (wb_stb_o) acc_stb_cycles++;
      if (cpu_wait_n_o) break;
      if (acc_cycles >= 200) begin
        check("access_budget", 64'(acc_cycles), 64'd0);
        break;
      end
    end
    acc_rdata  = cpu_dat_o;
    acc_berr   = cpu_berr_o;
    cpu_rd_n_i = 1'b1;
    cpu_wr_n_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    idle(3);
    rst_i = 1'b0;
    idle(1);
    check("rst_stb", 64'(wb_stb_o), 64'd0);
    check("rst_cyc", 64'(wb_cyc_o), 64'd0);
    check("rst_adr", 64'(wb_adr_o), 64'd0);
    check("rst_sel", 64'(wb_sel_o), 64'd0);
    check("rst_dat_o", 64'(cpu_dat_o), 64'd0);
    check("rst_berr", 64'(cpu_berr_o), 64'd0);
    check("rst_berr_addr", 64'(berr_addr_o), 64'd0);
    check("rst_wait_n", 64'(cpu_wait_n_o), 64'd1);

    // Zero-wait read.
    slv_waits = 0; slv_err = 1'b0; slv_data = 16'hBEEF;
    access(1'b0, 31'h1000, 16'h0000, 2'b00);
    check("rd_cycles", 64'(acc_cycles), 64'd2);
    check("rd_adr", 64'(acc_adr), 64'h2000);
    check("rd_sel", 64'(acc_sel), 64'h3);
    check("rd_we", 64'(acc_we), 64'd0);
    check("rd_stb_cycles", 64'(acc_stb_cycles), 64'd1);
    check("rd_data", 64'(acc_rdata), 64'hBEEF);
    check("rd_berr", 64'(acc_berr), 64'd0);
    idle(1);
    check("idle_berr_low", 64'(cpu_berr_o), 64'd0);
    check("idle_stb_low", 64'(wb_stb_o), 64'd0);
    idle(1);

    // Upper-byte write with three wait states.
    slv_waits = 3; slv_data = 16'h0000;
    access(1'b1, 31'h0042, 16'h12AB, 2'b01);
    check("wr_cycles", 64'(acc_cycles), 64'd5);
    check("wr_sel", 64'(acc_sel), 64'h2);
    check("wr_we", 64'(acc_we), 64'd1);
    check("wr_dat", 64'(acc_wdat), 64'h12AB);
    check("wr_adr", 64'(acc_adr), 64'h84);
    check("wr_stb_cycles", 64'(acc_stb_cycles), 64'd4);
    check("wr_berr", 64'(acc_berr), 64'd0);
    check("wr_keeps_dat_o", 64'(acc_rdata), 64'hBEEF);
    idle(2);

    // Error together with ack: error wins.
    slv_waits = 0; slv_err = 1'b1; slv_data = 16'h1234;
    access(1'b0, 31'h0345, 16'h0000, 2'b00);
    check("err_cycles", 64'(acc_cycles), 64'd2);
    check("err_berr", 64'(acc_berr), 64'd1);
    check("err_data", 64'(acc_rdata), 64'hFFFF);
    check("err_addr", 64'(berr_addr_o), 64'h68A);
    idle(1);
    check("err_berr_cleared", 64'(cpu_berr_o), 64'd0);
    check("err_addr_sticky", 64'(berr_addr_o), 64'h68A);
    idle(1);

    // Silent slave: TIMEOUT=8 aborts, timeout-disabled instance keeps waiting.
    slv_err = 1'b0; slv_silent = 1'b1;
    access(1'b0, 31'h0777, 16'h0000, 2'b00);
    check("tmo_stb_cycles", 64'(acc_stb_cycles), 64'd8);
    check("tmo_cycles", 64'(acc_cycles), 64'd9);
    check("tmo_berr", 64'(acc_berr), 64'd1);
    check("tmo_data", 64'(acc_rdata), 64'hFFFF);
    check("tmo_addr", 64'(berr_addr_o), 64'hEEE);
    idle(30);
    check("notmo_stb_held", 64'(z_wb_stb_o), 64'd1);
    check("notmo_wait_n", 64'(z_cpu_wait_n_o), 64'd0);
    check("notmo_adr", 64'(z_wb_adr_o), 64'hEEE);

    // Asynchronous reset in the middle of a bus cycle.
    cpu_addr_i = 31'h0555;
    cpu_rd_n_i = 1'b0;
    idle(2);
    check("pre_rst_stb", 64'(wb_stb_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_stb", 64'(wb_stb_o), 64'd0);
    check("arst_cyc", 64'(wb_cyc_o), 64'd0);
    check("arst_notmo_stb", 64'(z_wb_stb_o), 64'd0);
    check("arst_adr", 64'(wb_adr_o), 64'd0);
    check("arst_dat_o", 64'(cpu_dat_o), 64'd0);
    check("arst_berr_addr", 64'(berr_addr_o), 64'd0);
    check("arst_notmo_berr_addr", 64'(z_berr_addr_o), 64'd0);
    check("arst_wait_n_req", 64'(cpu_wait_n_o), 64'd0);
    cpu_rd_n_i = 1'b1;
    #1;
    check("arst_wait_n_idle", 64'(cpu_wait_n_o), 64'd1);
    idle(2);
    rst_i = 1'b0;
    slv_silent = 1'b0;
    idle(2);

    // No-lane write skips the bus, then a back-to-back read.
    slv_waits = 0; slv_data = 16'h5A5A;
    access(1'b1, 31'h0100, 16'hCAFE, 2'b11);
    check("nolane_cycles", 64'(acc_cycles), 64'd1);
    check("nolane_stb_cycles", 64'(acc_stb_cycles), 64'd0);
    check("nolane_berr", 64'(acc_berr), 64'd0);
    check("nolane_dat_o", 64'(acc_rdata), 64'd0);
    access(1'b0, 31'h0101, 16'h0000, 2'b00);
    check("b2b_cycles", 64'(acc_cycles), 64'd3);
    check("b2b_stb_cycles", 64'(acc_stb_cycles), 64'd1);
    check("b2b_data", 64'(acc_rdata), 64'h5A5A);
    check("b2b_berr", 64'(acc_berr), 64'd0);
    check("b2b_adr", 64'(wb_adr_o), 64'h202);
    check("b2b_notmo_data", 64'(z_cpu_dat_o), 64'h5A5A);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
